// File: rtl/ether_rx_pkg.sv
// ----------------------------------------------------------------------------
// ether_rx_pkg
// Shared types and constants for the Ethernet receive framer:
//   rx_state_t    framer state (IDLE / PREAMBLE / DATA / DROP)
//   ETH_PREAMBLE  preamble byte 0x55
//   ETH_SFD       start-of-frame delimiter 0xD5
//   CRC32_*       reflected CRC-32 polynomial, initial value, good-frame residue
//   crc32_byte()  advances a reflected CRC-32 register by one byte, LSB first
// ----------------------------------------------------------------------------
package ether_rx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ether_crc32_8.sv
// ----------------------------------------------------------------------------
// ether_crc32_8
// Byte-wise reflected CRC-32 register. No final inversion, so a frame that
// includes a correct FCS leaves the register at CRC32_RESIDUE.
// Ports:
//   clk    in   1   clock
//   reset  in   1   synchronous active-high reset (register -> CRC32_INIT)
//   init   in   1   reload CRC32_INIT (start of a new frame)
//   en     in   1   fold data into the register this cycle
//   data   in   8   byte to fold in
//   crc    out  32  current register value
// ----------------------------------------------------------------------------
module ether_crc32_8
    import ether_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] r_crc;

    always_ff @(posedge clk) begin
        if (reset || init) begin
            r_crc <= CRC32_INIT;
        end else if (en) begin
            r_crc <= crc32_byte(r_crc, data);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/ether_rx_frame.sv
// ----------------------------------------------------------------------------
// ether_rx_frame
// Ethernet receive framer on the RGMII byte stream (rx_clk domain). Strips
// preamble/SFD, checks the FCS, removes the 4 FCS bytes and emits the payload
// with last/user flags. No backpressure.
// Build option: define ETHER_RX_STATS_EN to build the statistics counters;
// otherwise stat_* are tied to zero.
// Ports:
//   rx_clk           in   1           clock
//   rx_reset         in   1           synchronous active-high reset
//   s_rx_data        in   8           received byte
//   s_rx_valid       in   1           RX_DV
//   s_rx_error       in   1           RX_DV xor RX_ER
//   m_data           out  8           payload byte
//   m_valid          out  1           m_data valid (one cycle per byte)
//   m_last           out  1           last payload byte of frame
//   m_user           out  1           frame error, qualified by m_valid & m_last
//   stat_frames      out  STAT_WIDTH  frames delivered
//   stat_crc_errors  out  STAT_WIDTH  frames delivered with bad FCS
//   stat_drops       out  STAT_WIDTH  frames discarded (bad preamble, runt)
// ----------------------------------------------------------------------------
module ether_rx_frame
    import ether_rx_pkg::*;
#(
    parameter int    MIN_FRAME  = 64,
    parameter int    MAX_FRAME  = 1518,
    parameter int    STAT_WIDTH = 32,
    parameter string DEBUG      = "false"
) (
    input  logic                  rx_clk,
    input  logic                  rx_reset,
    input  logic [7:0]            s_rx_data,
    input  logic                  s_rx_valid,
    input  logic                  s_rx_error,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    output logic                  m_last,
    output logic                  m_user,
    output logic [STAT_WIDTH-1:0] stat_frames,
    output logic [STAT_WIDTH-1:0] stat_crc_errors,
    output logic [STAT_WIDTH-1:0] stat_drops
);

    localparam logic [15:0] LP_MIN  = 16'(MIN_FRAME);
    localparam logic [15:0] LP_MAX  = 16'(MAX_FRAME);
    // FCS bytes held back in the delay line plus the pending byte.
    localparam logic [15:0] LP_PIPE = 16'd5;

    rx_state_t   r_state;
    rx_state_t   w_state_next;

    logic [7:0]  r_dly [4];
    logic [7:0]  r_pend;
    logic [15:0] r_len;
    logic        r_err;
    logic [7:0]  r_m_data;
    logic        r_m_valid;
    logic        r_m_last;
    logic        r_m_user;

    logic        w_er;
    logic        w_is_pre;
    logic        w_is_sfd;
    logic        w_sfd;
    logic        w_accept;
    logic        w_eof;
    logic        w_emit;
    logic        w_crc_bad;
    logic        w_bad;
    logic [31:0] w_crc;

    assign w_er     = s_rx_valid & (s_rx_valid ^ s_rx_error);
    assign w_is_pre = (s_rx_data == ETH_PREAMBLE);
    assign w_is_sfd = (s_rx_data == ETH_SFD);

    // State register
    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (s_rx_valid) begin
                    if (w_is_pre)      w_state_next = PREAMBLE;
                    else if (w_is_sfd) w_state_next = DATA;
                    else               w_state_next = DROP;
                end
            end
            PREAMBLE: begin
                if (!s_rx_valid)    w_state_next = IDLE;
                else if (w_is_sfd)  w_state_next = DATA;
                else if (!w_is_pre) w_state_next = DROP;
            end
            DATA:    if (!s_rx_valid) w_state_next = IDLE;
            DROP:    if (!s_rx_valid) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_sfd    = 1'b0;
        w_accept = 1'b0;
        w_eof    = 1'b0;
        case (r_state)
            IDLE, PREAMBLE: w_sfd = s_rx_valid & w_is_sfd;
            DATA: begin
                w_accept = s_rx_valid;
                w_eof    = ~s_rx_valid;
            end
            default: ;
        endcase
    end

    // r_len is the index of the byte being accepted (or the frame length at
    // end of frame); at least 5 bytes means the pending register holds payload.
    assign w_emit    = (r_len >= LP_PIPE);
    assign w_crc_bad = (w_crc != CRC32_RESIDUE);
    assign w_bad     = w_crc_bad | r_err | (r_len < LP_MIN) | (r_len > LP_MAX);

    ether_crc32_8 u_crc (
        .clk   (rx_clk),
        .reset (rx_reset),
        .init  (w_sfd),
        .en    (w_accept),
        .data  (s_rx_data),
        .crc   (w_crc)
    );

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            r_dly     <= '{default: '0};
            r_pend    <= '0;
            r_len     <= '0;
            r_err     <= 1'b0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_user  <= 1'b0;
        end else begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_user  <= 1'b0;
            if (w_sfd) begin
                r_len <= '0;
                r_err <= 1'b0;
            end
            if (w_accept) begin
                r_dly  <= '{s_rx_data, r_dly[0], r_dly[1], r_dly[2]};
                r_pend <= r_dly[3];
                r_len  <= (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
                r_err  <= r_err | w_er;
                if (w_emit) begin
                    r_m_data  <= r_pend;
                    r_m_valid <= 1'b1;
                end
            end
            if (w_eof && w_emit) begin
                r_m_data  <= r_pend;
                r_m_valid <= 1'b1;
                r_m_last  <= 1'b1;
                r_m_user  <= w_bad;
            end
        end
    end

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign m_user  = r_m_user;

`ifdef ETHER_RX_STATS_EN
    logic                  w_drop;
    logic [STAT_WIDTH-1:0] r_stat_frames;
    logic [STAT_WIDTH-1:0] r_stat_crc;
    logic [STAT_WIDTH-1:0] r_stat_drops;

    // Drops: entering DROP, preamble ending without SFD, or a runt frame.
    assign w_drop = ((w_state_next == DROP) && (r_state != DROP))
                  | ((r_state == PREAMBLE) && !s_rx_valid)
                  | (w_eof && !w_emit);

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            r_stat_frames <= '0;
            r_stat_crc    <= '0;
            r_stat_drops  <= '0;
        end else begin
            if (w_eof && w_emit) begin
                if (r_stat_frames != '1) r_stat_frames <= r_stat_frames + STAT_WIDTH'(1);
                if (w_crc_bad && (r_stat_crc != '1)) r_stat_crc <= r_stat_crc + STAT_WIDTH'(1);
            end
            if (w_drop && (r_stat_drops != '1)) r_stat_drops <= r_stat_drops + STAT_WIDTH'(1);
        end
    end

    assign stat_frames     = r_stat_frames;
    assign stat_crc_errors = r_stat_crc;
    assign stat_drops      = r_stat_drops;
`else
    assign stat_frames     = '0;
    assign stat_crc_errors = '0;
    assign stat_drops      = '0;
`endif

    if (DEBUG == "true") begin : g_debug
        (* mark_debug = "true" *) logic [1:0]  w_dbg_state;
        (* mark_debug = "true" *) logic [31:0] w_dbg_crc;
        assign w_dbg_state = r_state;
        assign w_dbg_crc   = w_crc;
    end

endmodule
